// File: rtl/rx_frame_ctrl.sv
// Frame receiver control: hunts for HDR_BYTE, collects LEN (1..4) payload bytes and publishes good frames.
// Build option RX_FRAME_CHECKSUM_EN adds the trailing checksum byte (LEN + payload, mod 256) and its check.
module rx_frame_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter logic [7:0]  HDR_BYTE    = 8'hAA
) (
   input  logic        CLOCK,
   input  logic        RST_n,
   input  logic        RX_Done_Sig,
   input  logic [7:0]  RX_Data,
   output logic        RX_En_Sig,
   output logic [31:0] Frame_Data,
   output logic [2:0]  Frame_Len,
   output logic        Frame_Valid,
   output logic        Frame_Err,
   output logic [7:0]  Number_Data,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_HDR = 3'd1,
      GET_LEN  = 3'd2,
      GET_DATA = 3'd3,
      GET_CSUM = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state, state_nxt;
   logic             ack_d;
   logic             acc;
   logic             in_frame;
   logic             timeout;
   logic             last_byte;
   logic             load_frame;
   logic             err_set;
   logic             start_len;
   logic [1:0]       idx;
   logic [2:0]       len_q;
   logic [31:0]      pay_q, pay_nxt;
   logic [CNT_W-1:0] to_cnt;
`ifdef RX_FRAME_CHECKSUM_EN
   logic [7:0]       sum_q;
`endif

   // Handshake: a byte is taken on a clock edge where RX_Done_Sig and RX_En_Sig are both 1
   // and no Frame_Err pulse is showing; RX_En_Sig then drops for exactly the following cycle.
   assign in_frame  = (state == GET_LEN) || (state == GET_DATA) || (state == GET_CSUM);
   assign RX_En_Sig = (in_frame || (state == WAIT_HDR)) && !ack_d;
   assign acc       = RX_Done_Sig && RX_En_Sig && !Frame_Err;
   assign timeout   = in_frame && !acc && (to_cnt == CNT_MAX);
   assign last_byte = ({1'b0, idx} == (len_q - 3'd1));
   assign dbg_state = state;

   always_ff @(posedge CLOCK) begin
      if (!RST_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_frame = 1'b0;
      err_set    = 1'b0;
      start_len  = 1'b0;
      pay_nxt    = pay_q;
      case (state)
         IDLE:     state_nxt = WAIT_HDR;
         WAIT_HDR: if (acc && (RX_Data == HDR_BYTE)) state_nxt = GET_LEN;
         GET_LEN: begin
            if (acc) begin
               if ((RX_Data != 8'd0) && (RX_Data <= 8'd4)) begin
                  start_len = 1'b1;
                  pay_nxt   = '0;
                  state_nxt = GET_DATA;
               end else begin
                  err_set   = 1'b1;
                  state_nxt = WAIT_HDR;
               end
            end
         end
         GET_DATA: begin
            if (acc) begin
               pay_nxt[{idx, 3'b000} +: 8] = RX_Data;
               if (last_byte) begin
`ifdef RX_FRAME_CHECKSUM_EN
                  state_nxt = GET_CSUM;
`else
                  load_frame = 1'b1;
                  state_nxt  = DONE;
`endif
               end
            end
         end
`ifdef RX_FRAME_CHECKSUM_EN
         GET_CSUM: begin
            if (acc) begin
               if (RX_Data == sum_q) begin
                  load_frame = 1'b1;
                  state_nxt  = DONE;
               end else begin
                  err_set   = 1'b1;
                  state_nxt = WAIT_HDR;
               end
            end
         end
`endif
         DONE:     state_nxt = WAIT_HDR;
         default:  state_nxt = IDLE;
      endcase
      // timeout is already qualified by !acc, so an arriving byte always wins the tie
      if (timeout) begin
         err_set   = 1'b1;
         state_nxt = WAIT_HDR;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RST_n) begin
         ack_d       <= 1'b0;
         idx         <= 2'd0;
         len_q       <= 3'd0;
         pay_q       <= 32'd0;
         to_cnt      <= '0;
         Frame_Data  <= 32'd0;
         Frame_Len   <= 3'd0;
         Number_Data <= 8'd0;
         Frame_Valid <= 1'b0;
         Frame_Err   <= 1'b0;
      end else begin
         ack_d       <= acc;
         Frame_Valid <= load_frame;
         Frame_Err   <= err_set;
         pay_q       <= pay_nxt;
         if (start_len) begin
            len_q <= RX_Data[2:0];
            idx   <= 2'd0;
         end else if (acc && (state == GET_DATA)) begin
            idx <= idx + 2'd1;
         end
         if (acc || !in_frame)  to_cnt <= '0;
         else if (!timeout)     to_cnt <= to_cnt + 1'b1;
         // pay_nxt already holds the final payload byte when it completes the frame
         if (load_frame) begin
            Frame_Data  <= pay_nxt;
            Frame_Len   <= len_q;
            Number_Data <= pay_nxt[7:0];
         end
      end
   end

`ifdef RX_FRAME_CHECKSUM_EN
   // running checksum starts from the LEN byte itself
   always_ff @(posedge CLOCK) begin
      if (!RST_n)                          sum_q <= 8'd0;
      else if (start_len)                  sum_q <= RX_Data;
      else if (acc && (state == GET_DATA)) sum_q <= sum_q + RX_Data;
   end
`endif

endmodule
